cache_miss_handler: RTL and testbench

- Requester-side controller for the team's small K-way cache.
- Accepts CPU load/store requests and drives the cache's channel-1 lookup/write port; channel 2 is not used.
- On a load miss, fetches the line from backing memory and fills the cache.
- Stores are write-through and write-allocate.
- Sits between the CPU pipeline and the cache/memory pair.

---
 rtl/cache_miss_handler_if.sv | 48 ++++
 rtl/cache_miss_handler.sv | 114 +++++++++++
 tb/tb_cache_miss_handler.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_miss_handler_if.sv
// Bundles the CPU request/response, cache channel-1 and backing-memory signals.
// master = the miss handler, slave = the CPU/cache/memory environment.
interface cache_miss_handler_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int LINE_WIDTH = 32
);
  logic                  cpu_req_valid;
  logic                  cpu_req_ready;
  logic                  cpu_req_we;
  logic [ADDR_WIDTH-1:0] cpu_req_addr;
  logic [LINE_WIDTH-1:0] cpu_req_wdata;
  logic                  cpu_resp_valid;
  logic [LINE_WIDTH-1:0] cpu_resp_data;
  logic                  cpu_resp_hit;

  logic [ADDR_WIDTH-1:0] c_addr;
  logic [LINE_WIDTH-1:0] c_val;
  logic                  c_read;
  logic                  c_write;
  logic                  c_hit;
  logic [LINE_WIDTH-1:0] c_out_val;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [LINE_WIDTH-1:0] mem_req_wdata;
  logic                  mem_resp_valid;
  logic [LINE_WIDTH-1:0] mem_resp_data;

  modport master (
    input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_data, cpu_resp_hit,
    output c_addr, c_val, c_read, c_write,
    input  c_hit, c_out_val,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_data, cpu_resp_hit,
    input  c_addr, c_val, c_read, c_write,
    output c_hit, c_out_val,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/cache_miss_handler.sv
// Single-outstanding-request controller between the CPU and a K-way cache:
// load lookup, miss fetch from memory, write-through/write-allocate stores.
module cache_miss_handler #(
  parameter int ADDR_WIDTH   = 8,
  parameter int LINE_WIDTH   = 32,
  parameter int FILL_TIMEOUT = 16,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  cache_miss_handler_if.master   bus,
  output logic [COUNT_WIDTH-1:0] hit_count,
  output logic [COUNT_WIDTH-1:0] miss_count,
  output logic                   fill_err
);
  localparam int FCW = $clog2(FILL_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, CHECK, MEM_REQ, MEM_WAIT, FILL, RESP
  } state_t;

  state_t                state_reg, state_next;
  logic                  we_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [LINE_WIDTH-1:0] wdata_reg;
  logic [LINE_WIDTH-1:0] data_reg;
  logic                  resp_hit_reg;
  logic [FCW-1:0]        fill_cnt_reg;
  logic                  ready_en_reg;

  logic accept;
  logic fill_done;
  logic fill_expire;

  assign accept      = (state_reg == IDLE) && ready_en_reg && bus.cpu_req_valid;
  // The cache's hit flag can be left over from the previous access on the first FILL cycle.
  assign fill_done   = (state_reg == FILL) && (fill_cnt_reg != '0) && bus.c_hit;
  assign fill_expire = (state_reg == FILL) && !fill_done &&
                       (fill_cnt_reg == FCW'(FILL_TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (accept) state_next = bus.cpu_req_we ? MEM_REQ : LOOKUP;
      LOOKUP:   state_next = CHECK;
      CHECK:    state_next = bus.c_hit ? RESP : MEM_REQ;
      MEM_REQ:  if (bus.mem_req_ready) state_next = we_reg ? FILL : MEM_WAIT;
      MEM_WAIT: if (bus.mem_resp_valid) state_next = FILL;
      FILL:     if (fill_done || fill_expire) state_next = RESP;
      RESP:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.cpu_req_ready  = (state_reg == IDLE) && ready_en_reg;
    bus.cpu_resp_valid = (state_reg == RESP);
    bus.cpu_resp_hit   = (state_reg == RESP) && resp_hit_reg;
    bus.c_read         = (state_reg == LOOKUP);
    bus.c_write        = (state_reg == FILL);
    bus.mem_req_valid  = (state_reg == MEM_REQ);
    bus.mem_req_we     = (state_reg == MEM_REQ) && we_reg;
  end

  // Address/value buses come straight from the request registers so they hold when idle.
  assign bus.c_addr        = addr_reg;
  assign bus.c_val         = data_reg;
  assign bus.mem_req_addr  = addr_reg;
  assign bus.mem_req_wdata = wdata_reg;
  assign bus.cpu_resp_data = data_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      data_reg     <= '0;
      resp_hit_reg <= 1'b0;
      fill_cnt_reg <= '0;
      ready_en_reg <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
      fill_err     <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      if (accept) begin
        we_reg       <= bus.cpu_req_we;
        addr_reg     <= bus.cpu_req_addr;
        wdata_reg    <= bus.cpu_req_wdata;
        resp_hit_reg <= 1'b0;
      end
      if (state_reg == CHECK) begin
        if (bus.c_hit) begin
          data_reg     <= bus.c_out_val;
          resp_hit_reg <= 1'b1;
          if (hit_count != '1) hit_count <= hit_count + 1'b1;
        end else if (miss_count != '1) begin
          miss_count <= miss_count + 1'b1;
        end
      end
      if ((state_reg == MEM_REQ) && bus.mem_req_ready && we_reg)
        data_reg <= wdata_reg;
      if ((state_reg == MEM_WAIT) && bus.mem_resp_valid)
        data_reg <= bus.mem_resp_data;
      fill_cnt_reg <= (state_reg == FILL) ? fill_cnt_reg + 1'b1 : '0;
      if (fill_expire) fill_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cache_miss_handler.sv
// Directed bench: 2-way cache model with slow eviction plus a 3-cycle memory
// model around cache_miss_handler; table of transactions plus corner sequences.
module tb_cache_miss_handler;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [15:0] hit_count, miss_count;
  logic fill_err;

  always #5 clock = ~clock;

  cache_miss_handler_if #(.ADDR_WIDTH(8), .LINE_WIDTH(32)) bus ();

  cache_miss_handler #(
    .ADDR_WIDTH(8), .LINE_WIDTH(32), .FILL_TIMEOUT(16), .COUNT_WIDTH(16)
  ) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus),
    .hit_count(hit_count), .miss_count(miss_count), .fill_err(fill_err)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- cache model: 2 entries, eviction needs 3 write cycles
  bit        c_hit_r;
  bit [31:0] c_out_r;
  bit        force_zero;
  bit        cvld [2];
  bit [7:0]  ctag [2];
  bit [31:0] cval [2];
  bit        ptr;
  int        ev_cnt;

  assign bus.c_hit     = c_hit_r & ~force_zero;
  assign bus.c_out_val = c_out_r;

  always @(posedge clock) begin
    if (bus.c_read) begin
      if (cvld[0] && ctag[0] == bus.c_addr) begin c_hit_r <= 1'b1; c_out_r <= cval[0]; end
      else if (cvld[1] && ctag[1] == bus.c_addr) begin c_hit_r <= 1'b1; c_out_r <= cval[1]; end
      else c_hit_r <= 1'b0;
    end else if (bus.c_write) begin
      if (cvld[0] && ctag[0] == bus.c_addr) begin cval[0] <= bus.c_val; c_hit_r <= 1'b1; end
      else if (cvld[1] && ctag[1] == bus.c_addr) begin cval[1] <= bus.c_val; c_hit_r <= 1'b1; end
      else if (!cvld[0]) begin cvld[0] <= 1'b1; ctag[0] <= bus.c_addr; cval[0] <= bus.c_val; c_hit_r <= 1'b1; end
      else if (!cvld[1]) begin cvld[1] <= 1'b1; ctag[1] <= bus.c_addr; cval[1] <= bus.c_val; c_hit_r <= 1'b1; end
      else if (ev_cnt < 2) begin ev_cnt <= ev_cnt + 1; c_hit_r <= 1'b0; end
      else begin
        ctag[ptr] <= bus.c_addr; cval[ptr] <= bus.c_val;
        ptr <= ~ptr; ev_cnt <= 0; c_hit_r <= 1'b1;
      end
    end
  end

  // ---------------- memory model: always ready, read data 3 cycles after accept
  bit        mem_rv;
  bit [31:0] mem_rd;
  bit [31:0] mem [256];
  bit        wr_vld [256];
  bit        pend;
  int        dly;
  bit [7:0]  raddr;

  function automatic bit [31:0] base_data(input bit [7:0] a);
    case (a)
      8'h10:   return 32'hDEADBEEF;
      8'h30:   return 32'hCAFEF00D;
      8'h40:   return 32'h0BADF00D;
      8'h50:   return 32'h5555AAAA;
      default: return {4{a}};
    endcase
  endfunction

  assign bus.mem_req_ready  = 1'b1;
  assign bus.mem_resp_valid = mem_rv;
  assign bus.mem_resp_data  = mem_rd;

  always @(posedge clock) begin
    mem_rv <= 1'b0;
    if (bus.mem_req_valid && bus.mem_req_ready) begin
      if (bus.mem_req_we) begin
        mem[bus.mem_req_addr] <= bus.mem_req_wdata;
        wr_vld[bus.mem_req_addr] <= 1'b1;
      end else begin
        pend <= 1'b1; dly <= 2; raddr <= bus.mem_req_addr;
      end
    end else if (pend) begin
      if (dly == 0) begin
        mem_rv <= 1'b1;
        mem_rd <= wr_vld[raddr] ? mem[raddr] : base_data(raddr);
        pend <= 1'b0;
      end else dly <= dly - 1;
    end
  end

  // ---------------- transactions
  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_hit;
    int          exp_lat;
    int          exp_reads;
    int          exp_fill;
  } vec_t;

  task automatic run_req(input vec_t v);
    int lat, nrd, nwr, guard;
    bit saw_we, got, hit;
    logic [31:0] data;
    lat = 0; nrd = 0; nwr = 0; guard = 0; saw_we = 0; got = 0; hit = 0; data = '0;
    while (!bus.cpu_req_ready && guard < 50) begin @(negedge clock); guard++; end
    check("req_ready", 64'(bus.cpu_req_ready), 64'd1);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_we    = v.we;
    bus.cpu_req_addr  = v.addr;
    bus.cpu_req_wdata = v.wdata;
    @(posedge clock); #1;
    bus.cpu_req_valid = 1'b0;
    while (!got && lat < 200) begin
      @(negedge clock);
      lat++;
      if (bus.c_read) nrd++;
      if (bus.c_write) nwr++;
      if (bus.c_read && bus.c_write) check("rd_wr_together", 64'd1, 64'd0);
      if (bus.mem_req_valid && bus.mem_req_we) saw_we = 1'b1;
      if (bus.cpu_resp_valid) begin got = 1'b1; data = bus.cpu_resp_data; hit = bus.cpu_resp_hit; end
    end
    $display("req we=%0b addr=%02h data=%08h hit=%0b lat=%0d reads=%0d fill=%0d",
             v.we, v.addr, data, hit, lat, nrd, nwr);
    check("resp_seen", 64'(got), 64'd1);
    check("resp_data", 64'(data), 64'(v.exp_data));
    check("resp_hit", 64'(hit), 64'(v.exp_hit));
    check("latency", 64'(lat), 64'(v.exp_lat));
    check("c_read_pulses", 64'(nrd), 64'(v.exp_reads));
    check("c_write_cycles", 64'(nwr), 64'(v.exp_fill));
    check("mem_we_seen", 64'(saw_we), 64'(v.we));
  endtask

  vec_t tbl [8];
  vec_t one;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int guard;
    bit quiet_bad;

    tbl[0] = '{1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0, 10, 1, 2};
    tbl[1] = '{1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b1,  3, 1, 0};
    tbl[2] = '{1'b1, 8'h20, 32'h12345678, 32'h12345678, 1'b0,  4, 0, 2};
    tbl[3] = '{1'b0, 8'h20, 32'h0,        32'h12345678, 1'b1,  3, 1, 0};
    tbl[4] = '{1'b0, 8'h30, 32'h0,        32'hCAFEF00D, 1'b0, 12, 1, 4};
    tbl[5] = '{1'b0, 8'h30, 32'h0,        32'hCAFEF00D, 1'b1,  3, 1, 0};
    tbl[6] = '{1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0, 12, 1, 4};
    tbl[7] = '{1'b0, 8'h20, 32'h0,        32'h12345678, 1'b0, 12, 1, 4};

    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_we    = 1'b0;
    bus.cpu_req_addr  = '0;
    bus.cpu_req_wdata = '0;
    force_zero = 1'b0;

    // reset state
    repeat (2) @(negedge clock);
    check("rst_ctrl", 64'({bus.cpu_req_ready, bus.cpu_resp_valid, bus.cpu_resp_hit, bus.c_read,
                          bus.c_write, bus.mem_req_valid, bus.mem_req_we, fill_err}), 64'd0);
    check("rst_counts", 64'({hit_count, miss_count}), 64'd0);
    check("rst_buses", 64'({bus.c_addr, bus.mem_req_addr, bus.cpu_resp_data}), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("ready_after_rst", 64'(bus.cpu_req_ready), 64'd1);

    for (int i = 0; i < 8; i++) run_req(tbl[i]);
    check("hit_count", 64'(hit_count), 64'd3);
    check("miss_count", 64'(miss_count), 64'd4);
    check("fill_err_clean", 64'(fill_err), 64'd0);

    // fill timeout: cache never acknowledges the write
    force_zero = 1'b1;
    one = '{1'b0, 8'h40, 32'h0, 32'h0BADF00D, 1'b0, 24, 1, 16};
    run_req(one);
    force_zero = 1'b0;
    check("fill_err_set", 64'(fill_err), 64'd1);
    check("miss_after_to", 64'(miss_count), 64'd5);
    one = '{1'b0, 8'h20, 32'h0, 32'h12345678, 1'b1, 3, 1, 0};
    run_req(one);
    check("fill_err_sticky", 64'(fill_err), 64'd1);
    check("hit_after_to", 64'(hit_count), 64'd4);

    // reset while waiting on memory
    @(negedge clock);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_we    = 1'b0;
    bus.cpu_req_addr  = 8'h50;
    @(posedge clock); #1;
    bus.cpu_req_valid = 1'b0;
    guard = 0;
    while (!bus.mem_req_valid && guard < 20) begin @(negedge clock); guard++; end
    check("mem_req_seen", 64'(bus.mem_req_valid), 64'd1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("rst_mid_ctrl", 64'({bus.cpu_req_ready, bus.cpu_resp_valid, bus.cpu_resp_hit, bus.c_read,
                              bus.c_write, bus.mem_req_valid, bus.mem_req_we, fill_err}), 64'd0);
    check("rst_mid_counts", 64'({hit_count, miss_count}), 64'd0);
    check("rst_mid_addr", 64'({bus.c_addr, bus.mem_req_addr}), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    quiet_bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (bus.cpu_resp_valid || bus.c_write || bus.mem_req_valid) quiet_bad = 1'b1;
    end
    check("late_resp_ignored", 64'(quiet_bad), 64'd0);
    check("ready_after_mid_rst", 64'(bus.cpu_req_ready), 64'd1);
    one = '{1'b1, 8'h60, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 6, 0, 4};
    run_req(one);
    one = '{1'b0, 8'h60, 32'h0, 32'hA5A5A5A5, 1'b1, 3, 1, 0};
    run_req(one);
    check("hit_post_rst", 64'(hit_count), 64'd1);
    check("miss_post_rst", 64'(miss_count), 64'd0);
    check("fill_err_post_rst", 64'(fill_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
